// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: fixed-priority DISP/CPU access to one BRAM with a CPU starvation guard and tagged read return
module bram_port_arbiter #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MAX_WAIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_req,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] disp_addr,
  output logic                          disp_ack,
  output logic                          disp_rvalid,
  output logic [7:0]                    disp_rdata,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic                          cpu_byte_enable,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                    cpu_wdata,
  output logic                          cpu_ack,
  output logic                          cpu_rvalid,
  output logic [7:0]                    cpu_rdata,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]                    mem_write_data,
  output logic                          mem_write_enable,
  output logic                          mem_byte_enable,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]                    mem_read_data
);
  localparam int CW = $clog2(C_MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  logic tag1_rd, tag1_cpu, tag2_rd, tag2_cpu;
  logic cpu_rd;
  always_comb begin
    cpu_ack = ~reset & cpu_req & (~disp_req | (wait_cnt == CW'(C_MAX_WAIT)));
    disp_ack = ~reset & disp_req & ~cpu_ack;
    cpu_rd = cpu_ack & ~cpu_we;
    cpu_rvalid = tag2_rd & tag2_cpu;
    disp_rvalid = tag2_rd & ~tag2_cpu;
    cpu_rdata = mem_read_data;
    disp_rdata = mem_read_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      tag1_rd <= 1'b0;
      tag1_cpu <= 1'b0;
      tag2_rd <= 1'b0;
      tag2_cpu <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_byte_enable <= 1'b0;
      mem_waddr <= '0;
      mem_write_data <= '0;
      mem_raddr <= '0;
    end else begin
      wait_cnt <= (cpu_req & ~cpu_ack) ? wait_cnt + 1'b1 : '0;
      tag1_rd <= cpu_rd | disp_ack;
      tag1_cpu <= cpu_rd;
      tag2_rd <= tag1_rd;
      tag2_cpu <= tag1_cpu;
      mem_write_enable <= cpu_ack & cpu_we;
      mem_raddr <= cpu_rd ? cpu_addr : disp_ack ? disp_addr : mem_raddr;
      if (cpu_ack & cpu_we) begin
        mem_waddr <= cpu_addr;
        mem_write_data <= cpu_wdata;
        mem_byte_enable <= cpu_byte_enable;
      end
    end
  end
endmodule
